// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between two requesters.
// Round-robin grant, latched request fields, wr/rd strobe sequencing,
// bounded wait for read status, and sign/zero extension of load data.
// Misaligned and illegal-mode accesses are answered with an error and
// never reach the memory.
module dmem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // requester 0: pipeline load/store stage
  input  logic             i_req0_valid,
  input  logic             i_req0_we,
  input  logic [WIDTH-1:0] i_req0_addr,
  input  logic [WIDTH-1:0] i_req0_wdata,
  input  logic [1:0]       i_req0_mode,
  input  logic             i_req0_signed,
  output logic             o_req0_ack,
  output logic             o_req0_done,
  output logic             o_req0_err,
  output logic [WIDTH-1:0] o_req0_rdata,
  // requester 1: debug/DMA port
  input  logic             i_req1_valid,
  input  logic             i_req1_we,
  input  logic [WIDTH-1:0] i_req1_addr,
  input  logic [WIDTH-1:0] i_req1_wdata,
  input  logic [1:0]       i_req1_mode,
  input  logic             i_req1_signed,
  output logic             o_req1_ack,
  output logic             o_req1_done,
  output logic             o_req1_err,
  output logic [WIDTH-1:0] o_req1_rdata,
  // data memory side
  output logic [WIDTH-1:0] o_mem_add,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_mem_wr,
  output logic             o_mem_rd,
  input  logic             i_mem_rd_st,
  output logic [1:0]       o_mem_mode
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  // Everything about one access that must be frozen at grant time.
  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       mode;
    logic             sgn;
  } req_t;

  state_t     r_state;
  state_t     w_next;
  req_t       r_req;
  req_t       w_req0;
  req_t       w_req1;
  req_t       w_req_sel;
  logic       r_last_grant;
  logic       r_grant;
  logic       r_err;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rdata0;
  logic [WIDTH-1:0] r_rdata1;

  logic             w_any_valid;
  logic             w_pick;
  logic             w_misaligned;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_timeout;
  logic             w_enter_resp;
  logic             w_resp_err;
  logic [WIDTH-1:0] w_resp_data;

  // Extend the right-justified memory data according to access size.
  function automatic logic [WIDTH-1:0] f_extend(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       mode,
                                                input logic             sgn);
    logic [WIDTH-1:0] res;
    case (mode)
      2'd2:    res = {{(WIDTH-8){sgn & d[7]}}, d[7:0]};
      2'd1:    res = {{(WIDTH-16){sgn & d[15]}}, d[15:0]};
      default: res = d;
    endcase
    return res;
  endfunction

  assign w_req0 = '{we: i_req0_we, addr: i_req0_addr, wdata: i_req0_wdata,
                    mode: i_req0_mode, sgn: i_req0_signed};
  assign w_req1 = '{we: i_req1_we, addr: i_req1_addr, wdata: i_req1_wdata,
                    mode: i_req1_mode, sgn: i_req1_signed};

  // Round-robin choice: on contention the requester not served last wins.
  always_comb begin
    w_any_valid = i_req0_valid | i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = i_req1_valid;
    end
    w_req_sel = w_pick ? w_req1 : w_req0;
  end

  // Alignment and mode legality of the latched access.
  always_comb begin
    case (r_req.mode)
      2'd0:    w_misaligned = (r_req.addr[1:0] != 2'b00);
      2'd1:    w_misaligned = r_req.addr[0];
      2'd2:    w_misaligned = 1'b0;
      default: w_misaligned = 1'b1;
    endcase
  end

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

  // Next-state logic of the access sequencer.
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_valid) w_next = S_SETUP;
      S_SETUP:  w_next = w_misaligned ? S_RESP : S_STROBE;
      S_STROBE: w_next = r_req.we ? S_RESP : S_WAIT;
      S_WAIT:   if (i_mem_rd_st || w_timeout) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Response contents, decided on the edge that enters RESP: only a load
  // that saw read status returns data; rejects, timeouts and stores return 0.
  always_comb begin
    w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    w_resp_err   = (r_state == S_SETUP) || ((r_state == S_WAIT) && !i_mem_rd_st);
    w_resp_data  = '0;
    if ((r_state == S_WAIT) && i_mem_rd_st) begin
      w_resp_data = f_extend(i_mem_rdata, r_req.mode, r_req.sgn);
    end
  end

  // State register, request latches, wait counter and per-requester results.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous, so it only takes effect on a rising clk edge.
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_req        <= w_req_sel;
            r_err        <= 1'b0;
            r_cnt        <= '0;
          end
        end
        S_WAIT: begin
          if (!i_mem_rd_st) r_cnt <= w_cnt_inc;
        end
        S_RESP: begin
          r_cnt <= '0;
        end
        default: ;
      endcase
      if (w_enter_resp) begin
        r_err <= w_resp_err;
        if (r_grant) begin
          r_rdata1 <= w_resp_data;
        end else begin
          r_rdata0 <= w_resp_data;
        end
      end
    end
  end

  // Requester handshakes are decoded from the state and the latched grant.
  always_comb begin
    o_req0_ack   = (r_state == S_SETUP) && !r_grant;
    o_req1_ack   = (r_state == S_SETUP) &&  r_grant;
    o_req0_done  = (r_state == S_RESP)  && !r_grant;
    o_req1_done  = (r_state == S_RESP)  &&  r_grant;
    o_req0_err   = o_req0_done && r_err;
    o_req1_err   = o_req1_done && r_err;
    o_req0_rdata = r_rdata0;
    o_req1_rdata = r_rdata1;
  end

  // Memory side: address/data/mode presented while an access is in flight,
  // strobes only in STROBE (write) or STROBE+WAIT (read).
  always_comb begin
    o_mem_add   = '0;
    o_mem_wdata = '0;
    o_mem_mode  = '0;
    if (r_state != S_IDLE) begin
      o_mem_add   = r_req.addr;
      o_mem_wdata = r_req.wdata;
      o_mem_mode  = r_req.mode;
    end
    o_mem_wr = (r_state == S_STROBE) && r_req.we;
    o_mem_rd = ((r_state == S_STROBE) || (r_state == S_WAIT)) && !r_req.we;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of directed accesses with
// hand-computed results, plus sequences for contention, withdrawal and
// reset in the middle of a read.
module tb_dmem_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_we, req0_signed;
  logic [WIDTH-1:0] req0_addr, req0_wdata;
  logic [1:0]       req0_mode;
  logic             req0_ack, req0_done, req0_err;
  logic [WIDTH-1:0] req0_rdata;
  logic             req1_valid, req1_we, req1_signed;
  logic [WIDTH-1:0] req1_addr, req1_wdata;
  logic [1:0]       req1_mode;
  logic             req1_ack, req1_done, req1_err;
  logic [WIDTH-1:0] req1_rdata;
  logic [WIDTH-1:0] mem_add, mem_wdata, mem_rdata;
  logic             mem_wr, mem_rd, mem_rd_st;
  logic [1:0]       mem_mode;

  logic             rd_st_en;
  logic [7:0]       mem [256] = '{default: 8'h00};
  logic [7:0]       a0, a1, a2, a3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .i_req0_mode(req0_mode), .i_req0_signed(req0_signed),
    .o_req0_ack(req0_ack), .o_req0_done(req0_done), .o_req0_err(req0_err),
    .o_req0_rdata(req0_rdata),
    .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .i_req1_mode(req1_mode), .i_req1_signed(req1_signed),
    .o_req1_ack(req1_ack), .o_req1_done(req1_done), .o_req1_err(req1_err),
    .o_req1_rdata(req1_rdata),
    .o_mem_add(mem_add), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_mem_wr(mem_wr), .o_mem_rd(mem_rd), .i_mem_rd_st(mem_rd_st),
    .o_mem_mode(mem_mode)
  );

  // Little-endian byte memory. Reads always return the full word starting
  // at the address, so the DUT itself must discard the unused upper bytes.
  assign a0 = mem_add[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign mem_rdata = mem_rd ? {mem[a3], mem[a2], mem[a1], mem[a0]} : '0;
  assign mem_rd_st = rd_st_en & mem_rd;

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_mode != 2'd2) mem[a1] <= mem_wdata[15:8];
      if (mem_mode == 2'd0) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    string            name;
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       mode;
    logic             sgn;
    logic             st;
    logic             chk_rd;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input string name, input logic req, input logic we,
                              input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                              input logic [1:0] mode, input logic sgn, input logic st,
                              input logic chk_rd, input logic [WIDTH-1:0] exp_rdata,
                              input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.mode = mode; v.sgn = sgn; v.st = st; v.chk_rd = chk_rd;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic we,
                       input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                       input logic [1:0] mode, input logic sgn);
    if (!r) begin
      req0_valid = v; req0_we = we; req0_addr = addr;
      req0_wdata = wdata; req0_mode = mode; req0_signed = sgn;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = addr;
      req1_wdata = wdata; req1_mode = mode; req1_signed = sgn;
    end
  endtask

  function automatic logic outputs_zero();
    return !(req0_ack | req0_done | req0_err | req1_ack | req1_done | req1_err |
             mem_wr | mem_rd | (|req0_rdata) | (|req1_rdata) | (|mem_add) |
             (|mem_wdata) | (|mem_mode));
  endfunction

  // One complete access: cycle numbers count falling edges after the rising
  // edge that first sees valid, so ack is expected at 1 and done at exp_lat.
  task automatic apply(input vec_t v);
    int   ack_cyc, done_cyc, wr_n, rd_n, wr_cyc, other_n, ack_n;
    logic got_err, strobe_at_done;
    logic [WIDTH-1:0] got_rdata;
    ack_cyc = -1; done_cyc = -1; wr_n = 0; rd_n = 0; wr_cyc = -1;
    other_n = 0; ack_n = 0; got_err = 1'b0; strobe_at_done = 1'b0; got_rdata = '0;
    @(negedge clk);
    rd_st_en = v.st;
    drive(v.req, 1'b1, v.we, v.addr, v.wdata, v.mode, v.sgn);
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (v.req ? req1_ack : req0_ack) begin
        ack_n++;
        if (ack_cyc < 0) ack_cyc = cyc;
        // Scramble the request after ack: the access in flight must not change.
        drive(v.req, 1'b0, ~v.we, ~v.addr, ~v.wdata, 2'd3, ~v.sgn);
      end
      if (v.req ? (req0_ack | req0_done) : (req1_ack | req1_done)) other_n++;
      if (mem_wr) begin wr_n++; wr_cyc = cyc; end
      if (mem_rd) rd_n++;
      if (v.req ? req1_done : req0_done) begin
        done_cyc       = cyc;
        got_err        = v.req ? req1_err : req0_err;
        got_rdata      = v.req ? req1_rdata : req0_rdata;
        strobe_at_done = mem_wr | mem_rd;
      end
    end
    check({v.name, " ack_cycle"}, WIDTH'(ack_cyc), 32'd1);
    check({v.name, " ack_count"}, WIDTH'(ack_n), 32'd1);
    check({v.name, " done_cycle"}, WIDTH'(done_cyc), WIDTH'(v.exp_lat));
    check({v.name, " err"}, WIDTH'(got_err), WIDTH'(v.exp_err));
    if (v.chk_rd) check({v.name, " rdata"}, got_rdata, v.exp_rdata);
    check({v.name, " other_requester_idle"}, WIDTH'(other_n), 32'd0);
    check({v.name, " strobes_low_at_done"}, WIDTH'(strobe_at_done), 32'd0);
    if (v.exp_lat == 2) begin
      check({v.name, " no_strobe"}, WIDTH'(wr_n + rd_n), 32'd0);
    end else if (v.we) begin
      check({v.name, " wr_cycles"}, WIDTH'(wr_n), 32'd1);
      check({v.name, " wr_at"}, WIDTH'(wr_cyc), 32'd2);
      check({v.name, " rd_cycles"}, WIDTH'(rd_n), 32'd0);
    end else begin
      check({v.name, " rd_cycles"}, WIDTH'(rd_n), WIDTH'(v.exp_lat - 2));
      check({v.name, " wr_cycles"}, WIDTH'(wr_n), 32'd0);
    end
    rd_st_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc_q[$];
    int ack_id_q[$];
    int overlap, ack1_n, done_cyc;
    logic done_err;

    //          name          req we addr      wdata         md sg st chk exp_rdata     err lat
    vecs[0]  = mk("st_word",   0, 1, 32'h4, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0,        0, 3);
    vecs[1]  = mk("ld_word",   1, 0, 32'h4, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF, 0, 4);
    vecs[2]  = mk("st_byte",   0, 1, 32'h5, 32'h00000080, 2, 0, 1, 0, 32'h0,        0, 3);
    vecs[3]  = mk("ld_sbyte",  1, 0, 32'h5, 32'h0,        2, 1, 1, 1, 32'hFFFFFF80, 0, 4);
    vecs[4]  = mk("ld_ubyte",  1, 0, 32'h5, 32'h0,        2, 0, 1, 1, 32'h00000080, 0, 4);
    vecs[5]  = mk("ld_shalf6", 0, 0, 32'h6, 32'h0,        1, 1, 1, 1, 32'hFFFFDEAD, 0, 4);
    vecs[6]  = mk("ld_uhalf4", 0, 0, 32'h4, 32'h0,        1, 0, 1, 1, 32'h000080EF, 0, 4);
    vecs[7]  = mk("ld_shalf4", 1, 0, 32'h4, 32'h0,        1, 1, 1, 1, 32'hFFFF80EF, 0, 4);
    vecs[8]  = mk("st_half",   1, 1, 32'h8, 32'h12347FFF, 1, 0, 1, 0, 32'h0,        0, 3);
    vecs[9]  = mk("ld_shalf8", 0, 0, 32'h8, 32'h0,        1, 1, 1, 1, 32'h00007FFF, 0, 4);
    vecs[10] = mk("ld_word8",  1, 0, 32'h8, 32'h0,        0, 0, 1, 1, 32'h00007FFF, 0, 4);
    vecs[11] = mk("mis_half",  0, 0, 32'h3, 32'h0,        1, 0, 1, 0, 32'h0,        1, 2);
    vecs[12] = mk("mis_word",  1, 1, 32'h6, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0,        1, 2);
    vecs[13] = mk("ill_mode",  0, 0, 32'h0, 32'h0,        3, 0, 1, 0, 32'h0,        1, 2);
    vecs[14] = mk("ld_word4",  0, 0, 32'h4, 32'h0,        0, 0, 1, 1, 32'hDEAD80EF, 0, 4);
    vecs[15] = mk("ld_sbyte7", 1, 0, 32'h7, 32'h0,        2, 1, 1, 1, 32'hFFFFFFDE, 0, 4);
    vecs[16] = mk("timeout",   1, 0, 32'h4, 32'h0,        0, 0, 0, 1, 32'h0,        1, 3 + TIMEOUT);
    vecs[17] = mk("ld_after",  1, 0, 32'h4, 32'h0,        0, 0, 1, 1, 32'hDEAD80EF, 0, 4);

    rst = 1'b1;
    rd_st_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", WIDTH'(outputs_zero()), 32'd1);

    // Contention from reset exit: both held valid, grants must alternate.
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h8, '0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    overlap = 0;
    for (int cyc = 1; cyc <= 40 && ack_id_q.size() < 4; cyc++) begin
      @(negedge clk);
      if (req0_ack && req1_ack) overlap++;
      if (req0_ack) begin ack_cyc_q.push_back(cyc); ack_id_q.push_back(0); end
      if (req1_ack) begin ack_cyc_q.push_back(cyc); ack_id_q.push_back(1); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("contention_ack_count", WIDTH'(ack_id_q.size()), 32'd4);
    check("contention_overlap", WIDTH'(overlap), 32'd0);
    for (int i = 0; i < 4 && i < ack_id_q.size(); i++) begin
      check($sformatf("contention_grant%0d", i), WIDTH'(ack_id_q[i]), WIDTH'(i % 2));
      check($sformatf("contention_ack_cycle%0d", i), WIDTH'(ack_cyc_q[i]), WIDTH'(1 + 5 * i));
    end
    repeat (6) @(negedge clk);

    for (int i = 0; i < 18; i++) apply(vecs[i]);

    // Withdrawn request: req1 raises valid while req0 is busy, then drops it.
    @(negedge clk);
    rd_st_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0, 2'd0, 1'b0);
    ack1_n = 0; done_cyc = -1; done_err = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (req0_ack) begin
        req0_valid = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h4, '0, 2'd0, 1'b0);
      end
      if (cyc == 4) req1_valid = 1'b0;
      if (req1_ack) ack1_n++;
      if (req0_done) begin done_cyc = cyc; done_err = req0_err; end
    end
    check("withdraw_no_ack1", WIDTH'(ack1_n), 32'd0);
    check("withdraw_done0_cycle", WIDTH'(done_cyc), WIDTH'(3 + TIMEOUT));
    check("withdraw_done0_err", WIDTH'(done_err), 32'd1);
    rd_st_en = 1'b1;

    // Reset while a read sits in WAIT.
    @(negedge clk);
    rd_st_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h4, '0, 2'd0, 1'b0);
    @(negedge clk);
    check("rstwait_ack0", WIDTH'(req0_ack), 32'd1);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstwait_in_wait_rd", WIDTH'(mem_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_outputs_zero", WIDTH'(outputs_zero()), 32'd1);
    rst = 1'b0;
    rd_st_en = 1'b1;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (req0_done || req1_done || mem_rd || mem_wr) done_cyc++;
    end
    check("rstwait_no_activity", WIDTH'(done_cyc), 32'd0);
    apply(vecs[14]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single data memory between requester 0 (pipeline load/store stage) and requester 1 (debug/DMA port).
- Arbitrates round-robin and latches address, data and mode.
- Sequences the memory's edge-triggered wr/rd strobes, waits for the read status, then sign- or zero-extends the read data back to the winning requester.
- Rejects misaligned and illegal-mode accesses without touching memory.

Parameters:
- WIDTH, 32, address/data width.
- TIMEOUT, 8, maximum cycles spent in WAIT before a read is aborted with error.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request pending, N=0,1; held high until reqN_ack.
- reqN_we  in  1  1=store, 0=load.
- reqN_addr  in  WIDTH  byte address.
- reqN_wdata  in  WIDTH  store data, right-justified.
- reqN_mode  in  2  0=word, 1=halfword, 2=byte, 3=illegal.
- reqN_signed  in  1  sign-extend load result.
- reqN_ack  out  1  one-cycle pulse: request latched.
- reqN_done  out  1  one-cycle pulse: access complete.
- reqN_err  out  1  valid with reqN_done: misaligned, illegal mode or timeout.
- reqN_rdata  out  WIDTH  load result, valid with reqN_done; holds until next done to same requester.
- mem_add  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data; the top level drives the bidirectional data bus when mem_wr=1.
- mem_rdata  in  WIDTH  memory read data.
- mem_wr  out  1  write strobe (memory acts on rising edge).
- mem_rd  out  1  read strobe (memory acts on rising edge, drives data while high).
- mem_rd_st  in  1  read status from memory.
- mem_mode  out  2  access mode to memory.

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1, timeout counter 0.
- A reset asserted mid-access behaves the same: strobes drop at that edge, the pending access is abandoned, and no done is issued.
- FSM states: IDLE, SETUP, STROBE, WAIT, RESP.
- IDLE:
  - If any valid is high, grant round-robin: if both are valid, grant the requester not equal to last_grant; if one is valid, grant it.
  - Latch that requester's fields, pulse its ack in the next cycle, update last_grant, go to SETUP.
  - At most one ack per cycle.
- SETUP (ack cycle):
  - Drive mem_add, mem_wdata and mem_mode from the latches; strobes stay 0.
  - Alignment check: word needs addr[1:0]=0, half needs addr[0]=0, mode 3 is always illegal.
  - On failure go to RESP with err=1 and no strobe ever asserted; otherwise go to STROBE.
- STROBE: assert mem_wr (store) or mem_rd (load) for this cycle.
  - Store: go to RESP.
  - Load: go to WAIT, with mem_rd held high.
- WAIT (load only):
  - mem_rd stays high.
  - If mem_rd_st=1, capture mem_rdata and go to RESP.
  - Otherwise increment the counter; when it reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- RESP:
  - All strobes 0; pulse done (and err if set) to the granted requester.
  - rdata is extended from the captured data: byte uses [7:0], half uses [15:0]; upper bits are filled with the sign bit if signed, else 0; word is passed unchanged.
  - Counter clears; go to IDLE.
  - The next grant can occur in the following cycle.
- Latency from valid seen in IDLE at edge T:
  - ack at T+1.
  - Store done at T+3.
  - Load done at T+4 when mem_rd_st is already 1.
  - Error done at T+2.
- Inputs changing after ack have no effect on the access in flight.
- A requester deasserting valid before ack is simply not granted; a withdrawn request is never acked.

Test Plan:
- Store word: req0 we=1, addr=0x4, wdata=0xDEADBEEF, mode=0 -> ack0 at T+1, mem_wr high only at T+2 with mem_add=0x4, done0 at T+3, err0=0.
- Signed byte load: memory byte 0x5 = 0x80, req1 we=0, addr=0x5, mode=2, signed=1 -> rdata1=0xFFFFFF80 at done1. The same request with signed=0 -> rdata1=0x00000080.
- Contention: both requests valid at reset exit -> req0 acked first, then req1. With both kept valid, grants alternate 0,1,0,1; no ack overlaps.
- Misaligned: req0 mode=1, addr=0x3 -> done0 and err0 at T+2; mem_wr and mem_rd never rise.
- Timeout: mem_rd_st tied 0, load via req1 -> err1=1 and rdata1=0 after TIMEOUT=8 WAIT cycles; mem_rd drops in RESP.
- Reset in WAIT: assert rst for one cycle -> mem_rd=0 and all outputs 0 at the next edge, no done pulse, and a new request is served normally afterwards.
